// File: rtl/serial_parallel.sv
// Serial-to-parallel receiver: locks byte alignment on a run of comma characters,
// then delivers each non-comma byte on Data_out with valid_out.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_INACTIVE | hunting for alignment: sliding comma search, then aligned comma run
// ST_ACTIVE   | aligned; payload bytes delivered at every byte boundary
module serial_parallel #(
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter int         ALIGN_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       Data_in,
    output logic [7:0] Data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int CW = $clog2(ALIGN_COUNT + 1);

    typedef enum logic {
        ST_INACTIVE = 1'b0,
        ST_ACTIVE   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      shift_q;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   comma_cnt_q, comma_cnt_d;
    logic [7:0]      data_d;
    logic            valid_d;
    logic [7:0]      window;
    logic            boundary;
    logic            is_comma;

    assign window   = {shift_q[6:0], Data_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_comma = (window == COMMA);
    assign active   = (state_q == ST_ACTIVE);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INACTIVE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            Data_out    <= '0;
            valid_out   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= window;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            Data_out    <= data_d;
            valid_out   <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        data_d      = Data_out;
        valid_d     = valid_out;

        case (state_q)
            ST_INACTIVE: begin
                if (comma_cnt_q == '0) begin
                    // First comma re-phases the bit counter so the next 8 bits are one byte
                    if (is_comma) begin
                        comma_cnt_d = CW'(1);
                        bit_cnt_d   = '0;
                    end
                end else if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + CW'(1);
                        if (comma_cnt_q == CW'(ALIGN_COUNT - 1)) begin
                            state_d = ST_ACTIVE;
                        end
                    end else begin
                        comma_cnt_d = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                // Idle commas are swallowed: Data_out keeps the last payload byte
                if (boundary) begin
                    if (is_comma) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = window;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_INACTIVE;
        endcase
    end

endmodule
